// File: rtl/priority_bit_iterator.sv
// Walks the set bits of each accepted request word and emits them one per beat
// as one-hot grants with a binary index, in LSB-first or MSB-first order.
module priority_bit_iterator #(
  parameter  int WIDTH      = 16,
  parameter  int MAX_GRANTS = WIDTH,
  localparam int IDX_W      = $clog2(WIDTH),
  localparam int CNT_W      = $clog2(MAX_GRANTS + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_last_o,
  output logic             grant_empty_o,
  output logic             grant_trunc_o,
  output logic             grant_val_o,
  input  logic             grant_rdy_i
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             empty_q, empty_d;
  logic             trunc_q, trunc_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             beat_acc, word_acc, load;
  logic [WIDTH-1:0] src, pk_grant, pk_rem;
  logic             src_dir;
  logic [CNT_W-1:0] src_cnt;
  logic [IDX_W-1:0] pk_idx;

  // Plain priority scan; the last hit in loop order wins, so the loop runs
  // away from the bit that should take priority. Works for any WIDTH.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v,
                                                input logic msb_first);
    pick_idx = '0;
    if (msb_first) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) pick_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i]) pick_idx = IDX_W'(i);
    end
  endfunction

  assign beat_acc   = (state_q == RUN) & grant_rdy_i;
  assign data_rdy_o = (state_q == IDLE) | (beat_acc & last_q);
  assign word_acc   = data_val_i & data_rdy_o;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    last_d     = last_q;
    empty_d    = empty_q;
    trunc_d    = trunc_q;
    residual_d = residual_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    src        = residual_q;
    src_dir    = dir_q;
    src_cnt    = cnt_q + CNT_W'(1);

    if (word_acc) begin
      load    = 1'b1;
      src     = data_i;
      src_dir = dir_i;
      src_cnt = CNT_W'(1);
    end else if (beat_acc && !last_q) begin
      load = 1'b1;
    end else if (beat_acc) begin
      state_d    = IDLE;
      grant_d    = '0;
      idx_d      = '0;
      last_d     = 1'b0;
      empty_d    = 1'b0;
      trunc_d    = 1'b0;
      residual_d = '0;
      cnt_d      = '0;
    end

    pk_idx   = pick_idx(src, src_dir);
    pk_grant = (src != '0) ? (WIDTH'(1) << pk_idx) : '0;
    pk_rem   = src & ~pk_grant;

    if (load) begin
      state_d    = RUN;
      grant_d    = pk_grant;
      idx_d      = pk_idx;
      residual_d = pk_rem;
      dir_d      = src_dir;
      cnt_d      = src_cnt;
      empty_d    = (src == '0);
      last_d     = (pk_rem == '0) | (src_cnt == CNT_W'(MAX_GRANTS));
      trunc_d    = (src_cnt == CNT_W'(MAX_GRANTS)) & (pk_rem != '0);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      empty_q    <= 1'b0;
      trunc_q    <= 1'b0;
      residual_q <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      empty_q    <= empty_d;
      trunc_q    <= trunc_d;
      residual_q <= residual_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_last_o  = last_q;
  assign grant_empty_o = empty_q;
  assign grant_trunc_o = trunc_q;
  assign grant_val_o   = (state_q == RUN);

endmodule

// File: tb/tb_priority_bit_iterator.sv
// Bench for priority_bit_iterator (WIDTH=16, MAX_GRANTS=4): directed scenarios
// plus random traffic against a list-of-set-bits reference model.
module tb_priority_bit_iterator;
  localparam int MG = 4;

  logic        clk = 1'b0, arst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        dir_i = 1'b0, data_val_i = 1'b0, grant_rdy_i = 1'b0;
  logic        data_rdy_o, grant_last_o, grant_empty_o, grant_trunc_o, grant_val_o;
  logic [15:0] grant_o;
  logic [3:0]  grant_idx_o;

  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic [15:0] g;
    logic [3:0]  idx;
    logic        last, empty, trunc;
  } beat_t;

  beat_t exp_q[$];

  priority_bit_iterator #(.WIDTH(16), .MAX_GRANTS(MG)) dut (
    .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .dir_i(dir_i),
    .data_val_i(data_val_i), .data_rdy_o(data_rdy_o), .grant_o(grant_o),
    .grant_idx_o(grant_idx_o), .grant_last_o(grant_last_o),
    .grant_empty_o(grant_empty_o), .grant_trunc_o(grant_trunc_o),
    .grant_val_o(grant_val_o), .grant_rdy_i(grant_rdy_i)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(input int g, input int idx, input bit last,
                               input bit empty, input bit trunc);
    beat_t b;
    b.g = 16'(g); b.idx = 4'(idx); b.last = last; b.empty = empty; b.trunc = trunc;
    return b;
  endfunction

  function automatic beat_t obs();
    return mk(int'(grant_o), int'(grant_idx_o), grant_last_o, grant_empty_o, grant_trunc_o);
  endfunction

  // Reference: list the set bit positions in the requested order, keep the first MG.
  function automatic void push_word(input logic [15:0] d, input logic dir);
    int pos[$];
    int n;
    for (int k = 0; k < 16; k++) begin
      int i = dir ? 15 - k : k;
      if (d[i]) pos.push_back(i);
    end
    if (pos.size() == 0) begin
      exp_q.push_back(mk(0, 0, 1, 1, 0));
      return;
    end
    n = (pos.size() < MG) ? pos.size() : MG;
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(1 << pos[k], pos[k], k == n - 1, 0, (k == n - 1) && (pos.size() > MG)));
  endfunction

  // Drive inputs just after the falling edge and settle; the next rising edge samples them.
  task automatic drive(input logic v, input logic [15:0] d, input logic dr, input logic r);
    @(negedge clk);
    data_val_i = v; data_i = d; dir_i = dr; grant_rdy_i = r;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({grant_val_o, grant_o, grant_idx_o, grant_last_o, grant_empty_o, grant_trunc_o} !== '0)
      $display("FAIL reset_outputs: got val=%b g=%h idx=%0d l=%b e=%b t=%b, want all 0",
               grant_val_o, grant_o, grant_idx_o, grant_last_o, grant_empty_o, grant_trunc_o);
    else n_pass++;
    @(negedge clk); arst_i = 1'b0; #1;
    n_chk++;
    if (data_rdy_o !== 1'b1) $display("FAIL reset_rdy: got %b want 1", data_rdy_o);
    else n_pass++;
  endtask

  task automatic test_order(input logic dir);
    beat_t e[4];
    if (!dir) begin
      e[0] = mk(16'h0001, 0, 0, 0, 0); e[1] = mk(16'h0020, 5, 0, 0, 0);
      e[2] = mk(16'h0400, 10, 0, 0, 0); e[3] = mk(16'h8000, 15, 1, 0, 0);
    end else begin
      e[0] = mk(16'h8000, 15, 0, 0, 0); e[1] = mk(16'h0400, 10, 0, 0, 0);
      e[2] = mk(16'h0020, 5, 0, 0, 0); e[3] = mk(16'h0001, 0, 1, 0, 0);
    end
    drive(1, 16'h8421, dir, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'hFFFF, ~dir, 1);
      n_chk++;
      if (!grant_val_o || obs() !== e[k])
        $display("FAIL order_dir%0d_beat%0d: got val=%b %h want %h", dir, k, grant_val_o, obs(), e[k]);
      else n_pass++;
      n_chk++;
      if (data_rdy_o !== (k == 3))
        $display("FAIL order_dir%0d_rdy%0d: got %b want %b", dir, k, data_rdy_o, k == 3);
      else n_pass++;
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (grant_val_o !== 1'b0) $display("FAIL order_dir%0d_idle: got val=%b want 0", dir, grant_val_o);
    else n_pass++;
  endtask

  task automatic test_zero();
    drive(1, 16'h0000, 0, 1);
    drive(0, 16'h1234, 0, 1);
    n_chk++;
    if (!grant_val_o || obs() !== mk(0, 0, 1, 1, 0))
      $display("FAIL zero_beat: got val=%b %h want %h", grant_val_o, obs(), mk(0, 0, 1, 1, 0));
    else n_pass++;
    drive(0, 0, 0, 1);
    n_chk++;
    if (grant_val_o !== 1'b0 || data_rdy_o !== 1'b1)
      $display("FAIL zero_idle: got val=%b rdy=%b want 0/1", grant_val_o, data_rdy_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(1, 16'h0006, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 16'h0001, 0, k == 3);
      n_chk++;
      if (!grant_val_o || obs() !== mk(16'h0002, 1, 0, 0, 0) || data_rdy_o !== 1'b0)
        $display("FAIL bp_hold%0d: got val=%b %h rdy=%b want %h rdy=0",
                 k, grant_val_o, obs(), data_rdy_o, mk(16'h0002, 1, 0, 0, 0));
      else n_pass++;
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (!grant_val_o || obs() !== mk(16'h0004, 2, 1, 0, 0))
      $display("FAIL bp_last: got val=%b %h want %h", grant_val_o, obs(), mk(16'h0004, 2, 1, 0, 0));
    else n_pass++;
    drive(0, 0, 0, 1);
  endtask

  task automatic test_trunc();
    beat_t e[6];
    e[0] = mk(16'h0001, 0, 0, 0, 0); e[1] = mk(16'h0002, 1, 0, 0, 0);
    e[2] = mk(16'h0004, 2, 0, 0, 0); e[3] = mk(16'h0008, 3, 1, 0, 1);
    e[4] = mk(16'h0200, 9, 0, 0, 0); e[5] = mk(16'h0100, 8, 1, 0, 0);
    drive(1, 16'h00FF, 0, 1);
    for (int k = 0; k < 6; k++) begin
      drive(k == 3, 16'h0300, 1, 1);
      n_chk++;
      if (!grant_val_o || obs() !== e[k])
        $display("FAIL trunc_beat%0d: got val=%b %h want %h", k, grant_val_o, obs(), e[k]);
      else n_pass++;
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (grant_val_o !== 1'b0) $display("FAIL trunc_idle: got val=%b want 0", grant_val_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_t e[3];
    e[0] = mk(16'h0001, 0, 0, 0, 0); e[1] = mk(16'h0002, 1, 1, 0, 0); e[2] = mk(16'h0100, 8, 1, 0, 0);
    drive(1, 16'h0003, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(k == 1, 16'h0100, 0, 1);
      n_chk++;
      if (!grant_val_o || obs() !== e[k])
        $display("FAIL b2b_beat%0d: got val=%b %h want %h", k, grant_val_o, obs(), e[k]);
      else n_pass++;
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    drive(1, 16'h000F, 0, 1);
    drive(0, 0, 0, 1);
    n_chk++;
    if (!grant_val_o || obs() !== mk(16'h0001, 0, 0, 0, 0))
      $display("FAIL rstmid_pre: got val=%b %h", grant_val_o, obs());
    else n_pass++;
    arst_i = 1'b1; #1;
    n_chk++;
    if ({grant_val_o, grant_o, grant_idx_o, grant_last_o, grant_empty_o, grant_trunc_o} !== '0)
      $display("FAIL rstmid_async: got val=%b g=%h idx=%0d want all 0", grant_val_o, grant_o, grant_idx_o);
    else n_pass++;
    @(negedge clk); arst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      n_chk++;
      if (grant_val_o !== 1'b0 || data_rdy_o !== 1'b1)
        $display("FAIL rstmid_after%0d: got val=%b rdy=%b want 0/1", k, grant_val_o, data_rdy_o);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    int guard;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'(1 << $urandom_range(0, 15));
        2: d = 16'($urandom);
        default: d = 16'($urandom & $urandom);
      endcase
      drive($urandom_range(0, 2) != 0, d, 1'($urandom), $urandom_range(0, 3) != 0);
      if (grant_val_o && grant_rdy_i) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL rand_extra_beat: got %h want none", obs());
        else begin
          beat_t e = exp_q.pop_front();
          if (obs() !== e) $display("FAIL rand_beat c%0d: got %h want %h", c, obs(), e);
          else n_pass++;
        end
      end
      if (data_val_i && data_rdy_o) push_word(data_i, dir_i);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      drive(0, 0, 0, 1);
      guard++;
      if (grant_val_o) begin
        beat_t e = exp_q.pop_front();
        n_chk++;
        if (obs() !== e) $display("FAIL rand_drain: got %h want %h", obs(), e);
        else n_pass++;
      end
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (exp_q.size() != 0 || grant_val_o !== 1'b0)
      $display("FAIL rand_end: got %0d pending val=%b want 0/0", exp_q.size(), grant_val_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_order(0);
    test_order(1);
    test_zero();
    test_backpressure();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
